// File: rtl/payload_char_feeder.sv
`default_nettype none
//==============================================================================
// Module   : payload_char_feeder
// Desc     : Feeds a payload byte stream into the engine array as sod/en/class
//            strobes, flushes the engine pipeline and returns a match report.
// Options  : PAYLOAD_CASE_FOLD_EN - fold 'A'..'Z' to lower case before lookup
//            when nocase is latched high at start of packet.
// Revision : 1.0 - initial release
//==============================================================================
module payload_char_feeder #(
    parameter int NUM_CLASSES  = 32,
    parameter int NUM_ENGINES  = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   nocase,
    input  logic                   tbl_we,
    input  logic [7:0]             tbl_addr,
    input  logic [NUM_CLASSES-1:0] tbl_data,
    output logic                   sod,
    output logic                   en,
    output logic [NUM_CLASSES-1:0] cls,
    input  logic [NUM_ENGINES-1:0] match_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NUM_ENGINES-1:0] m_match,
    output logic [15:0]            m_len
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SOD    = 3'd1;
    localparam logic [2:0] c_ST_STREAM = 3'd2;
    localparam logic [2:0] c_ST_FLUSH  = 3'd3;
    localparam logic [2:0] c_ST_REPORT = 3'd4;

    // Flush counter runs 0..FLUSH_CYCLES-1 with en high, then one quiet
    // cycle (== FLUSH_CYCLES) so the engine outputs settle before capture.
    localparam logic [4:0] c_FLUSH_LAST = 5'(FLUSH_CYCLES);
    localparam logic [4:0] c_FLUSH_CAP  = 5'(FLUSH_CYCLES + 1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   w_accept;
    logic [7:0]             w_lookup;
    logic [NUM_CLASSES-1:0] r_tbl [256];
    logic [15:0]            r_cnt;
    logic [4:0]             r_fcnt;
    logic                   r_en;
    logic [NUM_CLASSES-1:0] r_cls;
    logic [NUM_ENGINES-1:0] r_m_match;
    logic [15:0]            r_m_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        sod         = 1'b0;
        m_valid     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (s_valid) w_state_nxt = c_ST_SOD;
            end
            c_ST_SOD: begin
                sod         = 1'b1;
                w_state_nxt = c_ST_STREAM;
            end
            c_ST_STREAM: begin
                s_ready  = 1'b1;
                w_accept = s_valid;
                if (s_valid && s_last) w_state_nxt = c_ST_FLUSH;
            end
            c_ST_FLUSH: begin
                if (r_fcnt == c_FLUSH_CAP) w_state_nxt = c_ST_REPORT;
            end
            c_ST_REPORT: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

`ifdef PAYLOAD_CASE_FOLD_EN
    logic r_nocase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nocase <= 1'b0;
        end else if (r_state == c_ST_SOD) begin
            r_nocase <= nocase;
        end
    end

    always_comb begin
        w_lookup = s_data;
        if (r_nocase && (s_data >= 8'h41) && (s_data <= 8'h5A)) begin
            w_lookup = s_data + 8'h20;
        end
    end
`else
    logic w_unused_nocase;
    assign w_unused_nocase = nocase;
    assign w_lookup        = s_data;
`endif

    // Table is deliberately not reset; a same-edge write is seen by the next byte.
    always_ff @(posedge clk) begin
        if (tbl_we) r_tbl[tbl_addr] <= tbl_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_cls     <= '0;
            r_cnt     <= '0;
            r_fcnt    <= '0;
            r_m_match <= '0;
            r_m_len   <= '0;
        end else begin
            r_en  <= 1'b0;
            r_cls <= '0;
            case (r_state)
                c_ST_SOD: begin
                    r_cnt  <= '0;
                    r_fcnt <= '0;
                end
                c_ST_STREAM: begin
                    if (w_accept) begin
                        r_en  <= 1'b1;
                        r_cls <= r_tbl[w_lookup];
                        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_ST_FLUSH: begin
                    if (r_fcnt < c_FLUSH_LAST) r_en <= 1'b1;
                    if (r_fcnt == c_FLUSH_CAP) begin
                        r_m_match <= match_in;
                        r_m_len   <= r_cnt;
                    end else begin
                        r_fcnt <= r_fcnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign en      = r_en;
    assign cls     = r_cls;
    assign m_match = r_m_match;
    assign m_len   = r_m_len;

endmodule
`default_nettype wire

// File: tb/tb_payload_char_feeder.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_payload_char_feeder
// Desc     : Self-checking bench for payload_char_feeder; honours
//            PAYLOAD_CASE_FOLD_EN when computing expected class vectors.
// Revision : 1.0 - initial release
//==============================================================================
module tb_payload_char_feeder;

    localparam int NUM_CLASSES  = 32;
    localparam int NUM_ENGINES  = 8;
    localparam int FLUSH_CYCLES = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [7:0]             s_data = '0;
    logic                   s_valid = 1'b0;
    logic                   s_last = 1'b0;
    logic                   s_ready;
    logic                   nocase = 1'b0;
    logic                   tbl_we = 1'b0;
    logic [7:0]             tbl_addr = '0;
    logic [NUM_CLASSES-1:0] tbl_data = '0;
    logic                   sod;
    logic                   en;
    logic [NUM_CLASSES-1:0] cls;
    logic [NUM_ENGINES-1:0] match_in = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic [NUM_ENGINES-1:0] m_match;
    logic [15:0]            m_len;

    always #5 clk = ~clk;

    payload_char_feeder #(
        .NUM_CLASSES (NUM_CLASSES),
        .NUM_ENGINES (NUM_ENGINES),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .nocase  (nocase),
        .tbl_we  (tbl_we),
        .tbl_addr(tbl_addr),
        .tbl_data(tbl_data),
        .sod     (sod),
        .en      (en),
        .cls     (cls),
        .match_in(match_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_match (m_match),
        .m_len   (m_len)
    );

    typedef struct packed {
        logic [NUM_ENGINES-1:0] match;
        logic [15:0]            len;
        logic [31:0]            nen;
    } rpt_t;

    // Reference model state: class table, expected strobe stream, expected reports.
    logic [NUM_CLASSES-1:0] mdl_tbl [256];
    logic [NUM_CLASSES-1:0] exp_cls [$];
    rpt_t                   rpt_q [$];
    logic [7:0]             pkt [$];

    int nchk = 0;
    int nerr = 0;
    int n_started = 0;
    int n_sod = 0;

    bit                     rec = 1'b0;
    bit                     tr_sod [$];
    bit                     tr_en [$];
    bit                     tr_mv [$];
    logic [NUM_CLASSES-1:0] tr_cls [$];
    logic [15:0]            tr_len [$];
    logic [NUM_ENGINES-1:0] tr_match [$];
    bit                     ex_en [$];
    logic [NUM_CLASSES-1:0] ex_cls [$];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void fail_evt(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: got no event, want event", nm);
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] b, input bit nc);
        bit do_fold;
        do_fold = nc;
`ifndef PAYLOAD_CASE_FOLD_EN
        do_fold = 1'b0;
`endif
        if (do_fold && (b >= 8'h41) && (b <= 8'h5A)) return b + 8'h20;
        return b;
    endfunction

    // Compare process: every cycle, DUT outputs against the model's queues.
    bit   c_in_pkt = 1'b0;
    bit   c_mv_prev = 1'b0;
    bit   c_cur_ok = 1'b0;
    int   c_en_cnt = 0;
    rpt_t c_cur;
    logic [NUM_CLASSES-1:0] c_e;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rec) begin
                tr_sod.push_back(sod);
                tr_en.push_back(en);
                tr_mv.push_back(m_valid);
                tr_cls.push_back(cls);
                tr_len.push_back(m_len);
                tr_match.push_back(m_match);
            end
            if (!rst_n) begin
                c_in_pkt  = 1'b0;
                c_mv_prev = 1'b0;
            end else begin
                if (sod && en) check("sod_en_overlap", {sod, en}, 2'b10);
                if (sod) begin
                    n_sod++;
                    c_in_pkt = 1'b1;
                    c_en_cnt = 0;
                end
                if (en) begin
                    c_en_cnt++;
                    if (!c_in_pkt) fail_evt("en_outside_packet");
                    else if (exp_cls.size() == 0) fail_evt("en_extra_strobe");
                    else begin
                        c_e = exp_cls.pop_front();
                        check("cls_on_en", cls, c_e);
                    end
                end else begin
                    check("cls_idle_zero", cls, '0);
                end
                if (m_valid) begin
                    if (!c_mv_prev) begin
                        c_in_pkt = 1'b0;
                        if (rpt_q.size() == 0) begin
                            fail_evt("report_unexpected");
                            c_cur_ok = 1'b0;
                        end else begin
                            c_cur    = rpt_q.pop_front();
                            c_cur_ok = 1'b1;
                            check("en_count", c_en_cnt, c_cur.nen);
                            check("strobes_left", exp_cls.size(), 0);
                        end
                    end
                    if (c_cur_ok) begin
                        check("m_match", m_match, c_cur.match);
                        check("m_len", m_len, c_cur.len);
                    end
                    check("report_quiet", {s_ready, sod, en}, 3'b000);
                end
                c_mv_prev = m_valid;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input logic [7:0] a, input logic [NUM_CLASSES-1:0] d);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_data = d;
        mdl_tbl[a] = d;
        step();
        tbl_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_s_ready"}, s_ready, 1'b0);
        check({nm, "_sod_en"}, {sod, en}, 2'b00);
        check({nm, "_m_valid"}, m_valid, 1'b0);
        check({nm, "_cls"}, cls, '0);
        check({nm, "_m_match"}, m_match, '0);
        check({nm, "_m_len"}, m_len, 16'h0);
    endtask

    // Drives the bytes in pkt; gap_mode 0 none, 1 random gaps, 2 one gap after byte 0.
    task automatic send_pkt(input bit nc, input logic [NUM_ENGINES-1:0] mv, input int gap_mode,
                            input bit twr, input int abort_after, input int hold,
                            output logic [15:0] got_len);
        int n, i, budget, k;
        bit present, skipped, seen_en;
        logic [7:0] a;
        n        = pkt.size();
        i        = 0;
        skipped  = 1'b0;
        budget   = 4 * n + 64;
        got_len  = '0;
        nocase   = nc;
        match_in = ~mv;
        n_started++;
        while (i < n) begin
            present = 1'b1;
            if (gap_mode == 1 && $urandom_range(0, 3) == 0) present = 1'b0;
            if (gap_mode == 2 && i == 1 && !skipped) begin
                present = 1'b0;
                skipped = 1'b1;
            end
            s_valid = present;
            s_data  = pkt[i];
            s_last  = (i == n - 1);
            tbl_we  = 1'b0;
            if (present && s_ready) begin
                exp_cls.push_back(mdl_tbl[fold(pkt[i], nc)]);
                i++;
            end
            if (twr && $urandom_range(0, 4) == 0) begin
                a        = 8'($urandom);
                tbl_we   = 1'b1;
                tbl_addr = a;
                tbl_data = NUM_CLASSES'($urandom);
                mdl_tbl[a] = tbl_data;
            end
            step();
            budget--;
            if (abort_after > 0 && i == abort_after) begin
                rst_n   = 1'b0;
                s_valid = 1'b0;
                s_last  = 1'b0;
                tbl_we  = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_cls.delete();
                step();
                step();
                check("abort_no_report", m_valid, 1'b0);
                rst_n = 1'b1;
                step();
                check("abort_idle", {s_ready, sod, en, m_valid}, 4'b0000);
                return;
            end
            if (budget == 0) begin
                fail_evt("byte_accept_timeout");
                s_valid = 1'b0;
                tbl_we  = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tbl_we  = 1'b0;
        for (int f = 0; f < FLUSH_CYCLES; f++) exp_cls.push_back('0);
        rpt_q.push_back('{match: mv, len: (n > 65535) ? 16'hFFFF : 16'(n), nen: 32'(n + FLUSH_CYCLES)});
        // Engine outputs only become final once the strobes stop.
        seen_en = 1'b0;
        k = 0;
        while (!m_valid && k < 64) begin
            if (en) seen_en = 1'b1;
            else if (seen_en) match_in = mv;
            step();
            k++;
        end
        if (!m_valid) begin
            fail_evt("report_timeout");
            return;
        end
        got_len = m_len;
        for (int h = 0; h < hold; h++) step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("m_valid_after_ack", m_valid, 1'b0);
    endtask

    task automatic check_trace(input string nm, input int mv_at, input logic [15:0] len,
                               input logic [NUM_ENGINES-1:0] mt);
        int s;
        s = -1;
        for (int j = 0; j < tr_sod.size(); j++) begin
            if (s < 0 && tr_sod[j]) s = j;
        end
        if (s < 0 || s + mv_at >= tr_sod.size()) begin
            fail_evt({nm, "_trace_sod"});
            return;
        end
        check({nm, "_sod_pulse"}, {tr_sod[s], tr_sod[s+1]}, 2'b10);
        for (int j = 0; j < ex_en.size(); j++) begin
            check($sformatf("%s_en%0d", nm, j), tr_en[s+j], ex_en[j]);
            check($sformatf("%s_cls%0d", nm, j), tr_cls[s+j], ex_cls[j]);
        end
        check({nm, "_mv_edge"}, {tr_mv[s+mv_at-1], tr_mv[s+mv_at]}, 2'b01);
        check({nm, "_len"}, tr_len[s+mv_at], len);
        check({nm, "_match"}, tr_match[s+mv_at], mt);
    endtask

    task automatic start_trace();
        tr_sod.delete(); tr_en.delete(); tr_mv.delete();
        tr_cls.delete(); tr_len.delete(); tr_match.delete();
        rec = 1'b1;
    endtask

    logic [15:0] got_len;
    int          plen;

    initial begin : stim
        #1;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_after_reset", {s_ready, sod, en, m_valid}, 4'b0000);

        for (int a = 0; a < 256; a++) tbl_write(8'(a), NUM_CLASSES'($urandom));
        tbl_write(8'h43, 32'h1);
        tbl_write(8'h6F, 32'h2);
        tbl_write(8'h6E, 32'h8);
        tbl_write(8'h4E, 32'h40);

        // "Co": sod, two byte strobes, two flush strobes, quiet cycle, report.
        pkt = '{8'h43, 8'h6F};
        ex_en  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex_cls = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0};
        start_trace();
        send_pkt(1'b0, 8'h05, 0, 1'b0, 0, 10, got_len);
        rec = 1'b0;
        check_trace("co", 7, 16'd2, 8'h05);

        // One idle cycle between the two bytes.
        ex_en  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ex_cls = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0};
        start_trace();
        send_pkt(1'b0, 8'h3C, 2, 1'b0, 0, 0, got_len);
        rec = 1'b0;
        check_trace("gap", 8, 16'd2, 8'h3C);

        // 'N' with nocase requested.
        pkt = '{8'h4E};
`ifdef PAYLOAD_CASE_FOLD_EN
        ex_cls = '{32'h0, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0};
`else
        ex_cls = '{32'h0, 32'h0, 32'h40, 32'h0, 32'h0, 32'h0};
`endif
        ex_en  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        start_trace();
        send_pkt(1'b1, 8'h81, 0, 1'b0, 0, 1, got_len);
        rec = 1'b0;
        check_trace("fold", 6, 16'd1, 8'h81);

        // Reset after 5 accepted bytes of a 10-byte packet.
        pkt.delete();
        for (int j = 0; j < 10; j++) pkt.push_back(8'($urandom));
        send_pkt(1'b0, 8'hFF, 0, 1'b0, 5, 0, got_len);

        for (int p = 0; p < 25; p++) begin
            pkt.delete();
            plen = $urandom_range(1, 24);
            for (int j = 0; j < plen; j++) pkt.push_back(8'($urandom));
            send_pkt(1'($urandom), NUM_ENGINES'($urandom), 1, 1'b1, 0, $urandom_range(0, 5), got_len);
        end

        pkt.delete();
        for (int j = 0; j < 70000; j++) pkt.push_back(8'($urandom));
        send_pkt(1'b0, 8'hA5, 0, 1'b0, 0, 0, got_len);
        check("long_len_sat", got_len, 16'hFFFF);

        step();
        step();
        check("sod_per_packet", n_sod, n_started);
        check("reports_drained", rpt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
